instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory read port. It owns the program counter, drives the word read address into instructionmemory and captures the returned instruction word. Fetched {pc, instruction} pairs are buffered in a small FIFO and presented to decode over a valid/ready handshake. Supports branch/jump redirect with flush, and a halt on EBREAK.

Parameters:
INS_ADDRESS, 9, instruction memory word-address width; PC width is INS_ADDRESS+2 bits (byte address).
INS_W, 32, instruction width.
FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2.
RESET_PC, 0, byte address loaded into the PC on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
ra  output  INS_ADDRESS  word read address to instructionmemory; equals pc[INS_ADDRESS+1:2].
rd  input  INS_W  instruction word from instructionmemory; combinational, valid in the same cycle as ra.
redirect_valid  input  1  branch/jump taken; has priority over all other activity.
redirect_pc  input  INS_ADDRESS+2  byte target; bits [1:0] are ignored and treated as 0.
out_valid  output  1  buffer head holds a valid instruction.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  INS_W  head instruction.
out_pc  output  INS_ADDRESS+2  byte PC of the head instruction.
halted  output  1  high while in state HALTED.

Behaviour:
- Reset (synchronous): pc=RESET_PC; FIFO empty (count=0, read and write pointers 0); state=RUN; out_valid=0; halted=0; ra=RESET_PC>>2. out_instr and out_pc are 0 while the FIFO is empty.
- States: RUN and HALTED.
  - RUN -> HALTED: an entry is pushed whose instruction equals 32'h0010_0073 (EBREAK).
  - HALTED -> RUN: redirect_valid=1 only.
- pop = out_valid & out_ready.
- push = (state==RUN) & ~redirect_valid & (count<FIFO_DEPTH | pop).
- On push: write {pc, rd} at the write pointer; pc <= pc+4. PC arithmetic is modulo 2^(INS_ADDRESS+2), so the top word wraps to address 0.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Latency: an instruction is visible on out_* one cycle after its address was on ra. Throughput is 1 instruction/cycle when out_ready is held at 1.
- Redirect (highest priority):
  - Next cycle: FIFO flushed (count=0), pc={redirect_pc[hi:2],2'b00}, state=RUN.
  - No push occurs in the redirect cycle.
  - A pop in the same cycle is still accepted by the consumer, but the flush discards everything else.
  - The first redirected instruction appears on out_* two cycles after redirect_valid.
- HALTED: no pushes and the PC is frozen; buffered entries, including the EBREAK, still drain normally.
- out_instr and out_pc must stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation overrides redirect, push and pop in that cycle.
- count is INS_ADDRESS-independent: $clog2(FIFO_DEPTH)+1 bits, never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: two extra 32-bit outputs.
  - perf_fetch_cnt: increments on every push.
  - perf_stall_cnt: increments each cycle in RUN with ~redirect_valid where push=0 because the FIFO is full.
  - Both clear on reset and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory words 0..5 = 0x11..0x16, out_ready=1 -> out_valid rises 1 cycle after reset deasserts; out_pc=0,4,8,... with out_instr=0x11,0x12,... on consecutive cycles; ra increments by 1 per cycle.
- out_ready=0 for 5 cycles after reset -> FIFO fills to 2; ra holds at 2; out_pc=0 and out_instr stay stable; releasing out_ready drains pc 0 then 4, then fetch resumes at 8 with no gaps or duplicates.
- Redirect to 0x1A3 while the FIFO holds 2 entries -> next cycle out_valid=0; then out_pc=0x1A0 (low bits masked) and ra=0x68.
- Word 3 = 0x0010_0073 -> entries pc 0,4,8,12 delivered; halted=1; ra frozen at 4; no further out_valid after the EBREAK pops; redirect to 0 restarts fetch at pc 0.
- Start at RESET_PC=0x7FC with INS_ADDRESS=9 -> after pc 0x7FC the next out_pc=0x000 (wrap).
- With IFU_PERF_CNT_EN defined: 10 cycles running with out_ready=0 -> perf_fetch_cnt=2, perf_stall_cnt=8; reset clears both to 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, instruction-memory read port, small fetch FIFO toward decode.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter int                     INS_ADDRESS = 9,
    parameter int                     INS_W       = 32,
    parameter int                     FIFO_DEPTH  = 2,
    parameter logic [INS_ADDRESS+1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [INS_ADDRESS-1:0]   ra,
    input  logic [INS_W-1:0]         rd,
    input  logic                     redirect_valid,
    input  logic [INS_ADDRESS+1:0]   redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INS_W-1:0]         out_instr,
    output logic [INS_ADDRESS+1:0]   out_pc,
    output logic                     halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);
    localparam int PCW  = INS_ADDRESS + 2;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INS_W-1:0] EBREAK = INS_W'(32'h0010_0073);

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [PCW-1:0]   pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    state_t            state, state_nxt;
    logic [PCW-1:0]    pc;
    logic [PTRW-1:0]   wptr, rptr;
    logic [CNTW-1:0]   count;
    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            head;
    logic              push, pop;

    // Byte-offset bits of the target are defined as don't-care.
    wire unused_lsbs = ^redirect_pc[1:0];

    assign ra        = pc[PCW-1:2];
    assign head      = fifo_mem[rptr];
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;
    assign halted    = (state == HALTED);

    assign pop  = out_valid & out_ready;
    assign push = (state == RUN) & ~redirect_valid & ((count < CNTW'(FIFO_DEPTH)) | pop);

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = RUN;
        else if (push && rd == EBREAK)
            state_nxt = HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                // Flush: a same-cycle pop is consumed by decode, everything else is dropped.
                pc    <= {redirect_pc[PCW-1:2], 2'b00};
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc   <= pc + PCW'(4);
                    wptr <= wptr + PTRW'(1);
                end
                if (pop)
                    rptr <= rptr + PTRW'(1);
                count <= count + CNTW'(push) - CNTW'(pop);
            end
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && push)
            fifo_mem[wptr] <= '{pc: pc, instr: rd};
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            // In RUN without redirect, push is low only when the FIFO is full.
            if (state == RUN && !redirect_valid && !push && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect, EBREAK halt, PC wrap.
module tb_instruction_fetch_unit;
    localparam int IA = 9;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic            clk, reset;
    logic [IA-1:0]   ra, ra_w;
    logic [31:0]     rd, rd_w;
    logic            redirect_valid;
    logic [IA+1:0]   redirect_pc;
    logic            out_valid, out_ready;
    logic [31:0]     out_instr;
    logic [IA+1:0]   out_pc;
    logic            halted;
    logic            out_valid_w, halted_w;
    logic [31:0]     out_instr_w;
    logic [IA+1:0]   out_pc_w;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     perf_fetch_cnt, perf_stall_cnt;
    logic [31:0]     perf_fetch_cnt_w, perf_stall_cnt_w;
`endif

    logic [31:0] imem [1 << IA];
    assign rd   = imem[ra];
    assign rd_w = imem[ra_w];

    int total  = 0;
    int passed = 0;

    instruction_fetch_unit #(.INS_ADDRESS(IA), .INS_W(32), .FIFO_DEPTH(2), .RESET_PC(11'h000)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Second instance starting at the top word to exercise PC wrap.
    instruction_fetch_unit #(.INS_ADDRESS(IA), .INS_W(32), .FIFO_DEPTH(2), .RESET_PC(11'h7FC)) dut_w (
        .clk(clk), .reset(reset), .ra(ra_w), .rd(rd_w),
        .redirect_valid(1'b0), .redirect_pc(11'h000),
        .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w), .out_pc(out_pc_w),
        .halted(halted_w)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt_w), .perf_stall_cnt(perf_stall_cnt_w)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < (1 << IA); i++) imem[i] = 32'h11 + i;
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state and streaming at full rate
        step(); step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_ra", 64'(ra), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_ra_w", 64'(ra_w), 64'h1FF);
        chk("rst_valid_w", 64'(out_valid_w), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("run_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("run_pc%0d", k), 64'(out_pc), 64'(4 * k));
            chk($sformatf("run_instr%0d", k), 64'(out_instr), 64'(32'h11 + k));
            chk($sformatf("run_ra%0d", k), 64'(ra), 64'(k + 1));
            if (k == 0) begin
                chk("wrap_pc0", 64'(out_pc_w), 64'h7FC);
                chk("wrap_instr0", 64'(out_instr_w), 64'h210);
                chk("wrap_ra0", 64'(ra_w), 64'h0);
            end
            if (k == 1) begin
                chk("wrap_pc1", 64'(out_pc_w), 64'h000);
                chk("wrap_instr1", 64'(out_instr_w), 64'h11);
                chk("wrap_ra1", 64'(ra_w), 64'h1);
            end
        end

        // Backpressure: fill to 2, hold stable, then drain without gaps
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("bp_ra1", 64'(ra), 64'd1);
        step();
        chk("bp_ra2", 64'(ra), 64'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_ra%0d", k), 64'(ra), 64'd2);
            chk($sformatf("bp_hold_pc%0d", k), 64'(out_pc), 64'd0);
            chk($sformatf("bp_hold_instr%0d", k), 64'(out_instr), 64'h11);
            chk($sformatf("bp_hold_valid%0d", k), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("bp_drain_pc%0d", k), 64'(out_pc), 64'(4 * k));
            chk($sformatf("bp_drain_instr%0d", k), 64'(out_instr), 64'(32'h11 + k));
            chk($sformatf("bp_drain_ra%0d", k), 64'(ra), 64'(2 + k));
        end

        // Redirect with a full FIFO, unaligned target
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 11'h1A3;
        step();
        chk("rdr_valid", 64'(out_valid), 64'd0);
        chk("rdr_ra", 64'(ra), 64'h68);
        redirect_valid = 1'b0;
        step();
        chk("rdr_first_valid", 64'(out_valid), 64'd1);
        chk("rdr_first_pc", 64'(out_pc), 64'h1A0);
        chk("rdr_first_instr", 64'(out_instr), 64'h79);

        // EBREAK at word 3: halt, drain, restart by redirect
        imem[3] = EBRK;
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("brk_pc%0d", k), 64'(out_pc), 64'(4 * k));
            chk($sformatf("brk_instr%0d", k), 64'(out_instr), (k == 3) ? 64'(EBRK) : 64'(32'h11 + k));
            chk($sformatf("brk_halted%0d", k), 64'(halted), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("brk_ra_frozen", 64'(ra), 64'd4);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("halt_valid%0d", k), 64'(out_valid), 64'd0);
            chk($sformatf("halt_ra%0d", k), 64'(ra), 64'd4);
            chk($sformatf("halt_halted%0d", k), 64'(halted), 64'd1);
        end
        redirect_valid = 1'b1; redirect_pc = '0;
        step();
        chk("restart_halted", 64'(halted), 64'd0);
        chk("restart_valid", 64'(out_valid), 64'd0);
        chk("restart_ra", 64'(ra), 64'd0);
        redirect_valid = 1'b0;
        step();
        chk("restart_pc", 64'(out_pc), 64'd0);
        chk("restart_instr", 64'(out_instr), 64'h11);
        imem[3] = 32'h14;

`ifdef IFU_PERF_CNT_EN
        reset = 1'b1; out_ready = 1'b0;
        step();
        chk("perf_rst_fetch", 64'(perf_fetch_cnt), 64'd0);
        chk("perf_rst_stall", 64'(perf_stall_cnt), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'd2);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd8);
        reset = 1'b1;
        step();
        chk("perf_clr_fetch", 64'(perf_fetch_cnt), 64'd0);
        chk("perf_clr_stall", 64'(perf_stall_cnt), 64'd0);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
